// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
// Opcode encodings, flag bit positions, the reset flag value and the
// controller state encoding. Imported by every file of the ALU slice.
package alu_pkg;

    // Opcode encodings
    localparam logic [3:0] OP_OR   = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ONES = 4'b0011;
    localparam logic [3:0] OP_NEG  = 4'b0100;
    localparam logic [3:0] OP_ASL  = 4'b0101;
    localparam logic [3:0] OP_ASR  = 4'b0110;
    localparam logic [3:0] OP_LSL  = 4'b0111;
    localparam logic [3:0] OP_LSR  = 4'b1000;
    localparam logic [3:0] OP_ROL  = 4'b1001;
    localparam logic [3:0] OP_ROR  = 4'b1010;
    localparam logic [3:0] OP_ADD  = 4'b1011;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    // Flag bit positions inside oFlag
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_CARRY    = 1;
    localparam int FLAG_SIGN     = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_PARITY   = 4;
    localparam int FLAG_W        = 5;

    // Flags after reset: result is 0, so only Zero is set
    localparam logic [FLAG_W-1:0] FLAG_RESET = 5'b00001;

    // Controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bus of the sequential ALU.
// Handshake: a request transfers on a rising edge where iValid && oReady;
// iA/iB/iOpcode are sampled on that edge and the requester keeps them
// stable until it sees oReady high. oValid is a one-cycle pulse marking a
// freshly written oSalida/oFlag, which then stay stable until the next one.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic [3:0]       iOpcode;
    logic             oValid;
    logic [WIDTH-1:0] oSalida;
    logic [4:0]       oFlag;

    // Operand source side
    modport master (
        output iValid, iA, iB, iOpcode,
        input  oReady, oValid, oSalida, oFlag
    );

    // ALU side
    modport slave (
        input  iValid, iA, iB, iOpcode,
        output oReady, oValid, oSalida, oFlag
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial
// product bit per clock. start loads the operands (only issued while idle);
// busy is high for WIDTH cycles; done marks the final step, during which
// product_next already holds the complete 2*WIDTH-bit product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product_next
);
    localparam int CW = $clog2(WIDTH + 1);

    // acc holds {partial high half, remaining multiplier bits}; each step
    // conditionally adds the multiplicand to the high half, then shifts right.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;

    // One shift-add step plus load/count control
    always_comb begin
        addend  = acc_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        step    = {sum, acc_q[WIDTH-1:1]};
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start) begin
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            acc_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Multiplier state registers; reset discards any partial product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign done         = busy_q && (cnt_q == CW'(1));
    assign product_next = step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready request handshake.
// Single-cycle ops are computed combinationally from the request and
// written into the result/flag register on the accept edge. With the
// ALU_MUL_EN macro defined, opcode 1110 runs the shift-add multiplier in a
// BUSY state and oReady drops until it completes; without it 1110 behaves
// as an undefined opcode and oReady is constantly 1.
// oDbgState exposes the controller state for observation.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      iClk,
    input  logic      iRst_n,
    alu_seq_if.slave  bus,
    output state_e    oDbgState
);
    localparam int MSB = WIDTH - 1;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   salida_q, salida_d;
    logic [FLAG_W-1:0]  flag_q, flag_d;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [WIDTH:0]     add_full, sub_full;

    logic               is_mul;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_res;
    logic               wr_c, wr_v;
    logic [FLAG_W-1:0]  wr_flag;

    assign op_a = bus.iA;
    assign op_b = bus.iB;

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul    = (bus.iOpcode == OP_MUL);
    assign mul_start = (state_q == ST_IDLE) && bus.iValid && is_mul;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk          (iClk),
        .rst_n        (iRst_n),
        .start        (mul_start),
        .a            (op_a),
        .b            (op_b),
        .busy         (mul_busy),
        .done         (mul_done),
        .product_next (mul_prod)
    );

    assign bus.oReady = (state_q == ST_IDLE) && !mul_busy;
`else
    assign is_mul     = 1'b0;
    assign bus.oReady = 1'b1;
`endif

    // Single-cycle datapath: result, carry and overflow for each opcode
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        add_full = {1'b0, op_a} + {1'b0, op_b};
        sub_full = {1'b0, op_a} - {1'b0, op_b};
        case (bus.iOpcode)
            OP_ADD: begin
                alu_res = add_full[MSB:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_full[MSB:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT,
            OP_ONES: alu_res = ~op_a;
            OP_NEG: begin
                alu_res = -op_a;
                alu_c   = |op_a;
                alu_v   = op_a[MSB] && !(|op_a[MSB-1:0]);
            end
            OP_ASL: begin
                alu_res = {op_a[MSB-1:0], 1'b0};
                alu_c   = op_a[MSB];
                alu_v   = op_a[MSB] ^ op_a[MSB-1];
            end
            OP_ASR: begin
                alu_res = {op_a[MSB], op_a[MSB:1]};
                alu_c   = op_a[0];
            end
            OP_LSL: begin
                alu_res = {op_a[MSB-1:0], 1'b0};
                alu_c   = op_a[MSB];
            end
            OP_LSR: begin
                alu_res = {1'b0, op_a[MSB:1]};
                alu_c   = op_a[0];
            end
            OP_ROL: begin
                alu_res = {op_a[MSB-1:0], op_a[MSB]};
                alu_c   = op_a[MSB];
            end
            OP_ROR: begin
                alu_res = {op_a[0], op_a[MSB:1]};
                alu_c   = op_a[0];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // Controller next state and result/flag register write selection
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        salida_d = salida_q;
        flag_d   = flag_q;
        wr_en    = 1'b0;
        wr_res   = alu_res;
        wr_c     = alu_c;
        wr_v     = alu_v;
        case (state_q)
            ST_IDLE: begin
                if (bus.iValid) begin
                    if (is_mul) begin
                        state_d = ST_BUSY;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    wr_en   = 1'b1;
                    wr_res  = mul_prod[MSB:0];
                    wr_c    = |mul_prod[2*WIDTH-1:WIDTH];
                    wr_v    = |mul_prod[2*WIDTH-1:WIDTH];
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        wr_flag                = '0;
        wr_flag[FLAG_ZERO]     = (wr_res == '0);
        wr_flag[FLAG_CARRY]    = wr_c;
        wr_flag[FLAG_SIGN]     = wr_res[MSB];
        wr_flag[FLAG_OVERFLOW] = wr_v;
        wr_flag[FLAG_PARITY]   = ^wr_res;

        if (wr_en) begin
            valid_d  = 1'b1;
            salida_d = wr_res;
            flag_d   = wr_flag;
        end
    end

    // State, completion pulse and held result/flags
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            salida_q <= '0;
            flag_q   <= FLAG_RESET;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            salida_q <= salida_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.oValid  = valid_q;
    assign bus.oSalida = salida_q;
    assign bus.oFlag   = flag_q;
    assign oDbgState   = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq at WIDTH = 8.
// An arithmetic reference model predicts every completion and the ready
// level; a per-cycle compare process checks the DUT against it, and the
// directed vectors carry hand-computed literal results and flags.
// Exercises the MUL path when ALU_MUL_EN is defined, the undefined-1110
// behaviour otherwise.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e dbg_state;

    int checks = 0;
    int errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .bus       (bus),
        .oDbgState (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Generic comparison
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: result and flags {P,V,S,C,Z} from operand values
    function automatic void model_op(input logic [3:0] op, input logic [W-1:0] a_v,
                                     input logic [W-1:0] b_v, output logic [W-1:0] r,
                                     output logic [4:0] f);
        longint a = longint'(a_v);
        longint b = longint'(b_v);
        longint mask = (longint'(1) << W) - 1;
        longint half = longint'(1) << (W - 1);
        longint sa, sb, s, full, res;
        bit c = 1'b0;
        bit v = 1'b0;
        int ones = 0;
        full = 0;
        sa = (a >= half) ? a - (mask + 1) : a;
        sb = (b >= half) ? b - (mask + 1) : b;
        case (op)
            OP_ADD: begin
                full = a + b; c = (full > mask);
                s = sa + sb;  v = (s >= half) || (s < -half);
            end
            OP_SUB: begin
                full = a - b; c = (a < b);
                s = sa - sb;  v = (s >= half) || (s < -half);
            end
            OP_AND:  full = a & b;
            OP_OR:   full = a | b;
            OP_XOR:  full = a ^ b;
            OP_NOT, OP_ONES: full = mask - a;
            OP_NEG: begin full = -a; c = (a != 0); v = (a == half); end
            OP_ASL: begin
                full = a * 2; c = (a >= half);
                v = (a >= half) != (((a / (half / 2)) % 2) == 1);
            end
            OP_ASR: begin full = a / 2 + ((a >= half) ? half : 0); c = (a % 2 == 1); end
            OP_LSL: begin full = a * 2; c = (a >= half); end
            OP_LSR: begin full = a / 2; c = (a % 2 == 1); end
            OP_ROL: begin full = ((a * 2) & mask) + ((a >= half) ? 1 : 0); c = (a >= half); end
            OP_ROR: begin full = a / 2 + (a % 2) * half; c = (a % 2 == 1); end
`ifdef ALU_MUL_EN
            OP_MUL: begin full = a * b; c = (full > mask); v = c; end
`endif
            default: full = 0;
        endcase
        res = full & mask;
        for (int i = 0; i < W; i++) ones += int'((res >> i) & 1);
        r = res[W-1:0];
        f = {(ones % 2 == 1), v, (res >= half), c, (res == 0)};
    endfunction

    // Reference behaviour: ready level, completion pulses, expected queue
    logic [W+4:0] exp_q[$];
    logic         exp_valid = 1'b0;
    logic         exp_ready = 1'b1;
    int           busy_left = 0;
    logic [3:0]   mul_op;
    logic [W-1:0] mul_a, mul_b;

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] r;
        logic [4:0]   f;
        if (!rst_n) begin
            exp_q.delete();
            exp_valid = 1'b0;
            exp_ready = 1'b1;
            busy_left = 0;
        end else begin
            exp_valid = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    model_op(mul_op, mul_a, mul_b, r, f);
                    exp_q.push_back({r, f});
                    exp_valid = 1'b1;
                    exp_ready = 1'b1;
                end
            end else if (bus.iValid) begin
`ifdef ALU_MUL_EN
                if (bus.iOpcode == OP_MUL) begin
                    busy_left = W;
                    exp_ready = 1'b0;
                    mul_op = bus.iOpcode;
                    mul_a  = bus.iA;
                    mul_b  = bus.iB;
                end else
`endif
                begin
                    model_op(bus.iOpcode, bus.iA, bus.iB, r, f);
                    exp_q.push_back({r, f});
                    exp_valid = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the reference, away from the active edge
    logic [W-1:0] held_res = '0;
    logic [4:0]   held_flag = 5'b00001;

    always @(negedge clk) begin
        logic [W+4:0] e;
        if (!rst_n) begin
            held_res  = '0;
            held_flag = 5'b00001;
        end else begin
            chk("cyc_oValid", 64'(bus.oValid), 64'(exp_valid));
            chk("cyc_oReady", 64'(bus.oReady), 64'(exp_ready));
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("cyc_queue_empty", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    held_res  = e[W+4:5];
                    held_flag = e[4:0];
                end
            end
            chk("cyc_oSalida", 64'(bus.oSalida), 64'(held_res));
            chk("cyc_oFlag", 64'(bus.oFlag), 64'(held_flag));
        end
    end

    // Present one request; check the literal result one cycle after accept
    task automatic send_chk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] r, input logic [4:0] f);
        @(negedge clk);
        bus.iValid  = 1'b1;
        bus.iOpcode = op;
        bus.iA      = a;
        bus.iB      = b;
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 64'(bus.oValid), 64'(1));
        chk({name, "_res"}, 64'(bus.oSalida), 64'(r));
        chk({name, "_flag"}, 64'(bus.oFlag), 64'(f));
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.iValid = 1'b0;
    endtask

    task automatic lit_reset(input string name);
        chk({name, "_res"}, 64'(bus.oSalida), 64'(0));
        chk({name, "_flag"}, 64'(bus.oFlag), 64'(5'b00001));
        chk({name, "_ready"}, 64'(bus.oReady), 64'(1));
        chk({name, "_valid"}, 64'(bus.oValid), 64'(0));
    endtask

    // Directed stimulus
    initial begin
        logic [W-1:0] mr;
        logic [4:0]   mf;
        bus.iValid  = 1'b0;
        bus.iOpcode = 4'b0000;
        bus.iA      = '0;
        bus.iB      = '0;

        // Pin the reference model against hand-computed values
        model_op(OP_ADD, 8'h7F, 8'h01, mr, mf);
        chk("model_add", {mr, mf}, {8'h80, 5'b11100});
        model_op(OP_ROR, 8'h01, 8'h00, mr, mf);
        chk("model_ror", {mr, mf}, {8'h80, 5'b10110});

        #12;
        lit_reset("rst_init");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back single-cycle ops: oValid held high throughout
        send_chk("add_ovf",  OP_ADD,  8'h7F, 8'h01, 8'h80, 5'b11100);
        send_chk("sub_brw",  OP_SUB,  8'h00, 8'h01, 8'hFF, 5'b00110);
        send_chk("neg_min",  OP_NEG,  8'h80, 8'h00, 8'h80, 5'b11110);
        send_chk("asr",      OP_ASR,  8'h81, 8'h00, 8'hC0, 5'b00110);
        send_chk("ror",      OP_ROR,  8'h01, 8'h00, 8'h80, 5'b10110);
        send_chk("add_wrap", OP_ADD,  8'hFF, 8'h01, 8'h00, 5'b00011);
        send_chk("sub_ovf",  OP_SUB,  8'h80, 8'h01, 8'h7F, 5'b11000);
        send_chk("and",      OP_AND,  8'hF0, 8'h3C, 8'h30, 5'b00000);
        send_chk("or_zero",  OP_OR,   8'h00, 8'h00, 8'h00, 5'b00001);
        send_chk("xor",      OP_XOR,  8'hAA, 8'h55, 8'hFF, 5'b00100);
        send_chk("not",      OP_NOT,  8'h0F, 8'h00, 8'hF0, 5'b00100);
        send_chk("ones",     OP_ONES, 8'h00, 8'h00, 8'hFF, 5'b00100);
        send_chk("asl_ovf",  OP_ASL,  8'h40, 8'h00, 8'h80, 5'b11100);
        send_chk("lsl",      OP_LSL,  8'h81, 8'h00, 8'h02, 5'b10010);
        send_chk("lsr",      OP_LSR,  8'h01, 8'h00, 8'h00, 5'b00011);
        send_chk("rol",      OP_ROL,  8'h80, 8'h00, 8'h01, 5'b10010);
        send_chk("neg_zero", OP_NEG,  8'h00, 8'h00, 8'h00, 5'b00001);
        send_chk("nop",      OP_NOP,  8'h12, 8'h34, 8'h00, 5'b00001);
        go_idle();
        repeat (2) @(negedge clk);

`ifdef ALU_MUL_EN
        // MUL: ready low for W cycles, requests during BUSY ignored
        @(negedge clk);
        bus.iValid = 1'b1; bus.iOpcode = OP_MUL; bus.iA = 8'h10; bus.iB = 8'h11;
        @(negedge clk);
        bus.iOpcode = OP_ADD; bus.iA = 8'hFF; bus.iB = 8'hFF;
        chk("mul_busy_ready", 64'(bus.oReady), 64'(0));
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        chk("mul_valid", 64'(bus.oValid), 64'(1));
        chk("mul_ready", 64'(bus.oReady), 64'(1));
        chk("mul_res", 64'(bus.oSalida), 64'(8'h10));
        chk("mul_flag", 64'(bus.oFlag), 64'(5'b11010));
        go_idle();
        repeat (2) @(negedge clk);

        // Reset in BUSY cycle 3 discards the multiply
        @(negedge clk);
        bus.iValid = 1'b1; bus.iOpcode = OP_MUL; bus.iA = 8'h0F; bus.iB = 8'h0F;
        @(negedge clk);
        bus.iValid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 lit_reset("rst_busy");
`else
        // Without the multiplier 1110 is an undefined opcode
        send_chk("mul_undef", OP_MUL, 8'h10, 8'h11, 8'h00, 5'b00001);
        send_chk("add_pre",   OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b11100);
        go_idle();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 lit_reset("rst_mid");
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        send_chk("add_post_rst", OP_ADD, 8'h02, 8'h03, 8'h05, 5'b00000);
        go_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered arithmetic-logic unit with a valid/ready handshake. It is the next generation of the 4-bit lab ALU: operand width is a parameter, flags follow correct two's-complement rules, and an optional multi-cycle shift-add multiply holds off new requests while it runs. The block sits between an operand source (register file or test sequencer) and a result sink. Results and flags stay stable until the next completion.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 4 to 32.
- `iClk`  in  1: clock; all state changes on the rising edge.
- `iRst_n`  in  1: asynchronous active-low reset.
- `iValid`  in  1: request valid.
- `oReady`  out  1: unit can accept a request.
- `iA`  in  WIDTH: operand A.
- `iB`  in  WIDTH: operand B.
- `iOpcode`  in  4: operation select.
- `oValid`  out  1: one-cycle pulse when a new result is written.
- `oSalida`  out  WIDTH: result, held until the next completion.
- `oFlag`  out  5: flags, held with the result. Bit 0 Zero, bit 1 Carry, bit 2 Sign, bit 3 Overflow, bit 4 Parity.

## Operation
- A request is accepted on a rising edge where `iValid && oReady`. Operands and opcode are captured on that edge.
- Opcodes, with the Carry and Overflow rules for each:
  - 1011 ADD: Carry = carry-out; Overflow = signed overflow.
  - 1100 SUB: Carry = borrow (A < B unsigned); Overflow = signed overflow.
  - 1101 AND, 0000 OR, 0010 XOR: Carry = 0, Overflow = 0.
  - 0001 NOT and 0011 ONES (both ~A): Carry = 0, Overflow = 0.
  - 0100 NEG (two's complement, -A): Carry = (A != 0); Overflow = (A == most-negative value).
  - 0101 ASL: Carry = A[MSB]; Overflow = A[MSB] ^ A[MSB-1].
  - 0110 ASR (sign bit replicated): Carry = A[0].
  - 0111 LSL: Carry = A[MSB].
  - 1000 LSR: Carry = A[0].
  - 1001 ROL and 1010 ROR: Carry = the bit rotated across.
  - 1110 MUL: result = low WIDTH bits of A*B (unsigned); Carry = Overflow = any product high bit set.
  - 1111 and any disabled opcode: result 0, Carry 0, Overflow 0.
- Overflow is 0 for every opcode not listed with an Overflow rule above.
- Zero = (result == 0). Sign = result[MSB]. Parity = XOR of all result bits, so 1 means odd.
- State machine, two states:
  - IDLE: `oReady` = 1. A single-cycle op completes on the accept edge and stays in IDLE. MUL moves to BUSY and loads the cycle counter with WIDTH.
  - BUSY: `oReady` = 0. Each edge performs one shift-add step and decrements the counter. On the edge where the counter reaches 0, the unit writes the result and flags, pulses `oValid`, and returns to IDLE.
- `iValid` during BUSY is ignored. The requester must hold the request until it sees `oReady`.
- Reset (asynchronous, any time, including mid-MUL): state IDLE, `oReady` = 1, `oValid` = 0, `oSalida` = 0, `oFlag` = 5'b00001 (Zero set). Any partial product is discarded.

## Timing
- Single-cycle ops: latency 1. Accept on edge N gives `oValid` = 1 with the result in the cycle after edge N.
- Back-to-back single-cycle ops are accepted every cycle, so `oValid` stays high continuously.
- MUL: accept on edge N gives `oValid` in the cycle after edge N+WIDTH. `oReady` is low for exactly WIDTH cycles and rises in the same cycle `oValid` pulses.
- A new request is accepted on the edge that ends a MUL only if it is presented while `oReady` = 1, which means the edge after the completion edge.
- There is no combinational path from inputs to outputs.

## Configuration
- `ALU_MUL_EN` defined: MUL opcode 1110 and the BUSY state are compiled in.
- `ALU_MUL_EN` undefined:
  - 1110 completes in one cycle as an undefined opcode: result 0, flags 5'b00001.
  - `oReady` is tied to 1.
  - No multiplier logic is present.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (OP_ADD … OP_MUL);
  - flag bit indices (FLAG_ZERO … FLAG_PARITY);
  - the state encoding (ST_IDLE, ST_BUSY).
- Sub-module `alu_mul_seq` is the iterative shift-add multiplier with start, busy and done signals. It is instantiated only under `ALU_MUL_EN`.
- All other ops are combinational inside `alu_seq`, followed by the result/flag register.

## Test plan
All scenarios use WIDTH = 8.
- ADD 8'h7F + 8'h01: result 8'h80, flags Z0 C0 S1 V1 P1, `oValid` one cycle after accept.
- SUB 8'h00 - 8'h01: result 8'hFF, flags Z0 C1 S1 V0 P0. Then NEG 8'h80: result 8'h80, V1 C1.
- ASR 8'h81: result 8'hC0, C1. ROR 8'h01: result 8'h80, C1. Run back-to-back and check `oValid` on consecutive cycles.
- MUL 8'h10 × 8'h11: `oReady` low for 8 cycles, then result 8'h10, C1 V1. `iValid` during BUSY must not disturb the result.
- Assert `iRst_n` low in BUSY cycle 3: `oSalida` 0, `oFlag` 5'b00001, `oReady` 1, no `oValid`. A following ADD 8'h02 + 8'h03 gives 8'h05.
- Build without `ALU_MUL_EN`: opcode 1110 gives result 0 and flags 5'b00001 in one cycle, with `oReady` never low.
